// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem requests, prefetch FIFO to decode.
// Build option FETCH_PERF_EN adds the perf_fetched / perf_flushes counters.
module fetch_unit #(
   parameter int               ISIZE    = 16,
   parameter int               ASIZE    = 16,
   parameter int               DEPTH    = 2,
   parameter logic [ASIZE-1:0] RESET_PC = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [ASIZE-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [ISIZE-1:0] imem_rdata,
   output logic             instr_valid,
   output logic [ISIZE-1:0] instr_out,
   output logic [ASIZE-1:0] instr_pc,
   input  logic             instr_ready,
   input  logic             redir_en,
   input  logic [ASIZE-1:0] redir_addr,
   input  logic             exec_en,
   input  logic [ASIZE-1:0] exec_addr
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]      perf_fetched,
   output logic [15:0]      perf_flushes
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]      FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]      ZERO_CNT = {(PW+1){1'b0}};
   localparam logic [PW:0]      ONE_CNT  = {{PW{1'b0}}, 1'b1};
   localparam logic [PW-1:0]    ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [ASIZE-1:0] ONE_PC   = {{(ASIZE-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_FETCH      = 2'd0;
   localparam logic [1:0] ST_WAIT       = 2'd1;
   localparam logic [1:0] ST_EXEC_FETCH = 2'd2;
   localparam logic [1:0] ST_EXEC_WAIT  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [ASIZE-1:0] pc_q, pc_d;
   logic [ASIZE-1:0] exec_addr_q, exec_addr_d;
   logic             drop_q, drop_d;
   logic [ISIZE-1:0] word_q [DEPTH];
   logic [ASIZE-1:0] wpc_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;

   logic             req_s, pop_s, push_s, flush_s, outstanding_s;
   logic [ASIZE-1:0] addr_s, push_pc_s;
   logic [ISIZE-1:0] push_word_s;

   assign pop_s         = instr_ready && (count_q != ZERO_CNT);
   assign flush_s       = redir_en || exec_en;
   assign outstanding_s = (state_q == ST_WAIT) || (state_q == ST_EXEC_WAIT) || drop_q;

   // Request generation; a redirect/EXEC cycle never issues, so the new stream starts next cycle.
   always_comb begin
      req_s  = 1'b0;
      addr_s = pc_q;
      case (state_q)
         ST_FETCH: begin
            req_s  = !drop_q && (count_q < FULL_CNT);
            addr_s = pc_q;
         end
         ST_EXEC_FETCH: begin
            req_s  = !drop_q;
            addr_s = exec_addr_q;
         end
         default: begin
            req_s  = 1'b0;
            addr_s = pc_q;
         end
      endcase
   end

   assign imem_req  = rst && req_s && !flush_s;
   assign imem_addr = addr_s;

   // FSM next state, PC, drop flag and FIFO push; redirect outranks EXEC, both outrank the FSM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      exec_addr_d = exec_addr_q;
      drop_d      = drop_q;
      push_s      = 1'b0;
      push_word_s = imem_rdata;
      push_pc_s   = pc_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_req && imem_gnt) state_d = ST_WAIT;
            else                      state_d = ST_FETCH;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               push_s  = 1'b1;
               pc_d    = pc_q + ONE_PC;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_EXEC_FETCH: begin
            if (imem_req && imem_gnt) state_d = ST_EXEC_WAIT;
            else                      state_d = ST_EXEC_FETCH;
         end
         ST_EXEC_WAIT: begin
            if (imem_rvalid) begin
               push_s    = 1'b1;
               push_pc_s = exec_addr_q;
               state_d   = ST_FETCH;
            end else begin
               state_d = ST_EXEC_WAIT;
            end
         end
         default: state_d = ST_FETCH;
      endcase
      if (drop_q && imem_rvalid) drop_d = 1'b0;
      else                       drop_d = drop_q;
      // PC is held on EXEC so a flushed in-flight instruction is refetched on return.
      if (redir_en) begin
         state_d = ST_FETCH;
         pc_d    = redir_addr;
         drop_d  = outstanding_s && !imem_rvalid;
         push_s  = 1'b0;
      end else if (exec_en) begin
         state_d     = ST_EXEC_FETCH;
         pc_d        = pc_q;
         exec_addr_d = exec_addr;
         drop_d      = outstanding_s && !imem_rvalid;
         push_s      = 1'b0;
      end else begin
         exec_addr_d = exec_addr_q;
      end
   end

   // FIFO pointer and occupancy update; a flush wins over any same-cycle pop.
   always_comb begin
      if (flush_s) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = ZERO_CNT;
      end else begin
         wr_ptr_d = push_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
         rd_ptr_d = pop_s  ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
         count_d  = count_q + (push_s ? ONE_CNT : ZERO_CNT) - (pop_s ? ONE_CNT : ZERO_CNT);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         exec_addr_q <= {ASIZE{1'b0}};
         drop_q      <= 1'b0;
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= ZERO_CNT;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         exec_addr_q <= exec_addr_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= {ISIZE{1'b0}};
            wpc_q[i]  <= {ASIZE{1'b0}};
         end
      end else if (push_s) begin
         word_q[wr_ptr_q] <= push_word_s;
         wpc_q[wr_ptr_q]  <= push_pc_s;
      end else begin
         word_q[wr_ptr_q] <= word_q[wr_ptr_q];
      end
   end

   assign instr_valid = (count_q != ZERO_CNT);
   assign instr_out   = instr_valid ? word_q[rd_ptr_q] : {ISIZE{1'b0}};
   assign instr_pc    = instr_valid ? wpc_q[rd_ptr_q]  : {ASIZE{1'b0}};

`ifdef FETCH_PERF_EN
   logic        flush_hit_s;
   logic [15:0] fetched_q, flushes_q;

   assign flush_hit_s = flush_s && ((count_q > ONE_CNT) || ((count_q == ONE_CNT) && !pop_s) ||
                                    (outstanding_s && !imem_rvalid));

   // Performance counters, free-running with natural wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= 16'h0000;
         flushes_q <= 16'h0000;
      end else begin
         fetched_q <= pop_s       ? (fetched_q + 16'h0001) : fetched_q;
         flushes_q <= flush_hit_s ? (flushes_q + 16'h0001) : flushes_q;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_flushes = flushes_q;
`endif

endmodule
